// File: rtl/rat_io_ctrl.sv
// rat_io_ctrl: MCU port-bus I/O controller with synchronised inputs, output registers and change-detect IRQ.
// Latency: input change -> pending at 3rd edge -> INTERRUPT at 4th edge; writes land on the strobe edge; reads are combinational.
// Backpressure: none; every IO_STRB cycle is an independent write that is always accepted.
//
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   PORT_ID, OUT_PORT   MCU address and write data; IO_STRB qualifies a write
//   IN_PORT             MCU read data, decoded combinationally from PORT_ID
//   IN_DATA             N_IN asynchronous 8-bit input channels
//   OUT_DATA            N_OUT 8-bit output registers
//   INTERRUPT           registered OR of (pending & mask)
//
// Optional feature macro: RAT_IO_RDBACK_EN - output register IDs read back their contents.
module rat_io_ctrl #(
    parameter int         N_IN     = 12,
    parameter int         N_OUT    = 4,
    parameter logic [7:0] IN_BASE  = 8'h91,
    parameter logic [7:0] OUT_BASE = 8'h40,
    parameter logic [7:0] STAT_ID  = 8'hA0,
    parameter logic [7:0] MASK_ID  = 8'hA2,
    parameter logic [7:0] ACK_ID   = 8'hA4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [7:0]           PORT_ID,
    input  logic [7:0]           OUT_PORT,
    input  logic                 IO_STRB,
    output logic [7:0]           IN_PORT,
    input  logic [8*N_IN-1:0]    IN_DATA,
    output logic [8*N_OUT-1:0]   OUT_DATA,
    output logic                 INTERRUPT
);

    logic [8*N_IN-1:0]  sync1_q, sync1_d;
    logic [8*N_IN-1:0]  sync2_q, sync2_d;
    logic [8*N_IN-1:0]  prev_q,  prev_d;
    logic [8*N_OUT-1:0] out_q,   out_d;
    logic [15:0]        mask_q,  mask_d;
    logic [15:0]        pend_q,  pend_d;
    logic               irq_q,   irq_d;
    logic [15:0]        chg;
    logic [15:0]        clr;
    logic [7:0]         rd_dat;

    // Range compare done in 9 bits so a range running past 8'hFF never
    // aliases back onto low IDs.
    function automatic logic id_hit(input logic [7:0] base, input int off, input logic [7:0] id);
        return ({1'b0, base} + 9'(off)) == {1'b0, id};
    endfunction

    always_comb begin
        sync1_d = IN_DATA;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        out_d   = out_q;
        mask_d  = mask_q;
        clr     = '0;
        chg     = '0;

        // Only channels that exist can raise a change; upper pending bits stay 0.
        for (int i = 0; i < N_IN; i++) begin
            chg[i] = |(sync2_q[8*i +: 8] ^ prev_q[8*i +: 8]);
        end

        if (IO_STRB) begin
            for (int j = 0; j < N_OUT; j++) begin
                if (id_hit(OUT_BASE, j, PORT_ID)) begin
                    out_d[8*j +: 8] = OUT_PORT;
                end
            end
            for (int b = 0; b < 2; b++) begin
                if (id_hit(MASK_ID, b, PORT_ID)) begin
                    mask_d[8*b +: 8] = OUT_PORT;
                end
                if (id_hit(ACK_ID, b, PORT_ID)) begin
                    clr[8*b +: 8] = OUT_PORT;
                end
            end
        end

        // A new change in the same cycle as its ack keeps the flag set.
        pend_d = (pend_q & ~clr) | chg;
        irq_d  = |(pend_q & mask_q);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            out_q   <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            out_q   <= out_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            irq_q   <= irq_d;
        end
    end

    // Read mux: sources are applied lowest priority first so later
    // assignments (inputs last) win when ranges overlap.
    always_comb begin
        rd_dat = 8'h00;
`ifdef RAT_IO_RDBACK_EN
        for (int j = 0; j < N_OUT; j++) begin
            if (id_hit(OUT_BASE, j, PORT_ID)) begin
                rd_dat = out_q[8*j +: 8];
            end
        end
`endif
        for (int b = 0; b < 2; b++) begin
            if (id_hit(MASK_ID, b, PORT_ID)) begin
                rd_dat = mask_q[8*b +: 8];
            end
        end
        for (int b = 0; b < 2; b++) begin
            if (id_hit(STAT_ID, b, PORT_ID)) begin
                rd_dat = pend_q[8*b +: 8];
            end
        end
        for (int i = 0; i < N_IN; i++) begin
            if (id_hit(IN_BASE, i, PORT_ID)) begin
                rd_dat = sync2_q[8*i +: 8];
            end
        end
    end

    assign IN_PORT   = rd_dat;
    assign OUT_DATA  = out_q;
    assign INTERRUPT = irq_q;

endmodule
